// File: rtl/i_raster_counter.sv
// Raster column/row index generator with programmable width, height and column stride.
// Outputs are registered: one cycle from an enabled advance or accepted start to visible result.
module i_raster_counter #(
  parameter int CNT_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 count_enable,
  input  logic [CNT_WIDTH-1:0] img_width,
  input  logic [CNT_WIDTH-1:0] img_height,
  input  logic [CNT_WIDTH-1:0] col_step,
  input  logic                 continuous,
  output logic [CNT_WIDTH-1:0] col_value,
  output logic [CNT_WIDTH-1:0] row_value,
  output logic                 col_rollover,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_width;
  logic [CNT_WIDTH-1:0] r_height;
  logic [CNT_WIDTH-1:0] r_step;
  logic                 r_cont;
  logic [CNT_WIDTH-1:0] r_col;
  logic [CNT_WIDTH-1:0] r_row;
  logic                 r_roll;
  logic                 r_fd;
  logic                 r_err;

  logic                 w_cfg_ok;
  logic                 w_accept;
  logic [CNT_WIDTH:0]   w_col_sum;
  logic                 w_wrap;
  logic                 w_last_row;
  logic                 w_frame_end;

  assign w_cfg_ok    = (|img_width) && (|img_height) && (|col_step);
  assign w_accept    = (r_state == IDLE) && start && w_cfg_ok;
  // One extra bit keeps col + step exact even at the maximum dimension.
  assign w_col_sum   = {1'b0, r_col} + {1'b0, r_step};
  assign w_wrap      = (w_col_sum >= {1'b0, r_width});
  assign w_last_row  = (r_row == (r_height - ONE));
  assign w_frame_end = (r_state == RUN) && count_enable && w_wrap && w_last_row;

  always_ff @(posedge clk) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) begin
      if (w_accept) w_state_nxt = RUN;
    end else begin
      if (w_frame_end && !r_cont) w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_width  <= '0;
      r_height <= '0;
      r_step   <= '0;
      r_cont   <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_roll   <= 1'b0;
      r_fd     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fd  <= 1'b0;
      r_err <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_width  <= img_width;
          r_height <= img_height;
          r_step   <= col_step;
          r_cont   <= continuous;
          r_col    <= '0;
          r_row    <= '0;
        end else if (start) begin
          r_err <= 1'b1;
        end
      end else if (count_enable) begin
        if (w_wrap) begin
          r_col  <= '0;
          r_roll <= 1'b1;
          if (w_last_row) begin
            r_row <= '0;
            r_fd  <= 1'b1;
          end else begin
            r_row <= r_row + ONE;
          end
        end else begin
          r_col  <= w_col_sum[CNT_WIDTH-1:0];
          r_roll <= 1'b0;
        end
      end
    end
  end

  assign col_value    = r_col;
  assign row_value    = r_row;
  assign col_rollover = r_roll;
  assign frame_done   = r_fd;
  assign busy         = (r_state == RUN);
  assign cfg_err      = r_err;

endmodule

// File: tb/tb_i_raster_counter.sv
// Scoreboard bench for i_raster_counter: driver queues expected outputs, monitor checks them.
module tb_i_raster_counter;
  localparam int W = 13;

  logic         clk;
  logic         clear;
  logic         start;
  logic         count_enable;
  logic [W-1:0] img_width;
  logic [W-1:0] img_height;
  logic [W-1:0] col_step;
  logic         continuous;
  logic [W-1:0] col_value;
  logic [W-1:0] row_value;
  logic         col_rollover;
  logic         frame_done;
  logic         busy;
  logic         cfg_err;

  typedef struct packed {
    logic [W-1:0] col;
    logic [W-1:0] row;
    logic         ro;
    logic         fd;
    logic         bz;
    logic         er;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  i_raster_counter #(.CNT_WIDTH(W)) dut (
    .clk(clk), .clear(clear), .start(start), .count_enable(count_enable),
    .img_width(img_width), .img_height(img_height), .col_step(col_step),
    .continuous(continuous), .col_value(col_value), .row_value(row_value),
    .col_rollover(col_rollover), .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_tests++;
      if (col_value !== e.col || row_value !== e.row || col_rollover !== e.ro ||
          frame_done !== e.fd || busy !== e.bz || cfg_err !== e.er) begin
        n_fail++;
        $display("FAIL %s: got col=%0d row=%0d ro=%b fd=%b busy=%b err=%b, want col=%0d row=%0d ro=%b fd=%b busy=%b err=%b",
                 t, col_value, row_value, col_rollover, frame_done, busy, cfg_err,
                 e.col, e.row, e.ro, e.fd, e.bz, e.er);
      end
    end
  end

  task automatic cfg(input int w, input int h, input int s, input bit c);
    img_width  = W'(w);
    img_height = W'(h);
    col_step   = W'(s);
    continuous = c;
  endtask

  // Drive one clock cycle of stimulus and queue the outputs expected after that edge.
  task automatic cyc(input string tag, input bit st, input bit en, input bit clr,
                     input int c, input int r, input bit ro, input bit fd,
                     input bit bz, input bit er);
    exp_t e;
    start        = st;
    count_enable = en;
    clear        = clr;
    @(posedge clk);
    #1;
    e.col = W'(c);
    e.row = W'(r);
    e.ro  = ro;
    e.fd  = fd;
    e.bz  = bz;
    e.er  = er;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    start        = 1'b0;
    count_enable = 1'b0;
    clear        = 1'b0;
  endtask

  initial begin
    start = 0; count_enable = 0; clear = 0;
    cfg(0, 0, 0, 0);

    cyc("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Single frame 10x3, stride 1; config changes and start mid-run must be ignored.
    cfg(10, 3, 1, 0);
    cyc("s1_start", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 30; i++) begin
      cyc("s1_adv", 0, 1, 0, i % 10, (i / 10) % 3, (i % 10) == 0, i == 30, i < 30, 0);
      if (i == 5) cyc("s1_hold", 0, 0, 0, 5, 0, 0, 0, 1, 0);
      if (i == 15) begin
        cfg(4, 1, 2, 1);
        cyc("s1_start_in_run", 1, 0, 0, 5, 1, 0, 0, 1, 0);
      end
    end
    cyc("s1_idle_en_ignored", 0, 1, 0, 0, 0, 1, 0, 0, 0);

    // Stride 3 over width 10.
    cyc("s2_clear", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cfg(10, 2, 3, 0);
    cyc("s2_start", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("s2_adv1", 0, 1, 0, 3, 0, 0, 0, 1, 0);
    cyc("s2_adv2", 0, 1, 0, 6, 0, 0, 0, 1, 0);
    cyc("s2_adv3", 0, 1, 0, 9, 0, 0, 0, 1, 0);
    cyc("s2_adv4_wrap", 0, 1, 0, 0, 1, 1, 0, 1, 0);
    cyc("s2_adv5", 0, 1, 0, 3, 1, 0, 0, 1, 0);

    // Continuous 2x2 frames, then abort with clear.
    cyc("s3_clear", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cfg(2, 2, 1, 1);
    cyc("s3_start", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++)
      cyc("s3_adv", 0, 1, 0, i % 2, (i / 2) % 2, (i % 2) == 0, (i % 4) == 0, 1, 0);
    cyc("s3_abort", 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Rejected configurations, clear priority over start, then clear during a run.
    cfg(10, 0, 1, 0);
    cyc("s4_rej_h0", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("s4_err_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cfg(0, 3, 1, 0);
    cyc("s4_rej_w0", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cfg(10, 3, 0, 0);
    cyc("s4_rej_s0", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cfg(10, 3, 1, 0);
    cyc("s4_clear_over_start", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("s4_accept", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 15; i++)
      cyc("s4_adv", 0, 1, 0, i % 10, i / 10, (i % 10) == 0, 0, 1, 0);
    cyc("s4_clear_run", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("s4_after_clear", 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Stride larger than width: every advance wraps.
    cfg(5, 2, 7, 0);
    cyc("s5_start", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("s5_adv1", 0, 1, 0, 0, 1, 1, 0, 1, 0);
    cyc("s5_adv2", 0, 1, 0, 0, 0, 1, 1, 0, 0);

    // Maximum stride with height 1 in continuous mode.
    cyc("s6_clear", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cfg(8000, 1, 8191, 1);
    cyc("s6_start", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("s6_adv1", 0, 1, 0, 0, 0, 1, 1, 1, 0);
    cyc("s6_adv2", 0, 1, 0, 0, 0, 1, 1, 1, 0);

    // Maximum width, single row.
    cyc("s7_clear", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cfg(8191, 1, 1, 0);
    cyc("s7_start", 1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 8190; i++)
      cyc("s7_adv", 0, 1, 0, i, 0, 0, 0, 1, 0);
    cyc("s7_wrap", 0, 1, 0, 0, 0, 1, 1, 0, 0);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
